// File: rtl/load_unit_pkg.sv
// Shared load-path definitions: {funct3, opcode} load encodings, FSM state
// encoding and the alignment rule used by the load unit.
package load_unit_pkg;

    localparam int DATA_BUS_BITS = 32;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [9:0] LB  = {F3_LB,  OPC_LOAD};
    localparam logic [9:0] LH  = {F3_LH,  OPC_LOAD};
    localparam logic [9:0] LW  = {F3_LW,  OPC_LOAD};
    localparam logic [9:0] LBU = {F3_LBU, OPC_LOAD};
    localparam logic [9:0] LHU = {F3_LHU, OPC_LOAD};

    typedef enum logic [1:0] {
        LU_IDLE = 2'd0,
        LU_REQ  = 2'd1,
        LU_WAIT = 2'd2,
        LU_RESP = 2'd3
    } lu_state_e;

    // funct3[1:0] encodes the access size for every load: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_unit_extend.sv
// Combinational byte/halfword select and sign/zero extension of a read word.
module load_extend
    import load_unit_pkg::*;
#(
    parameter int DATA_W = DATA_BUS_BITS
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  ext = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_LH:   ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
            F3_LHU:  ext = {{(DATA_W-16){1'b0}}, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: decodes a load, issues a word read over req/gnt/rvalid,
// extends the result and returns it as a one-cycle writeback strobe.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int DATA_W         = DATA_BUS_BITS,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] addr,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              load_misaligned,
    output logic              access_fault,
    output logic [1:0]        fsm_state
);

    // Handshake: mem_req stays high with a stable mem_addr until mem_gnt is
    // seen; mem_rvalid is honoured only in WAIT, at the earliest one cycle after gnt.

    lu_state_e         state, state_next;
    logic [9:0]        op;
    logic              op_valid, accept, misaligned, timeout_hit, resp;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] word_q, res_q, ext_word;
    logic              mis_q, flt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              unused_instr_bits;

    assign op                = {instruction[14:12], instruction[6:0]};
    assign unused_instr_bits = ^{instruction[DATA_W-1:15], instruction[11:7]};

    always_comb begin
        case (op)
            LB, LH, LW, LBU, LHU: op_valid = 1'b1;
            default:              op_valid = 1'b0;
        endcase
    end

    assign accept      = start && (state == LU_IDLE) && op_valid;
    assign misaligned  = is_misaligned(instruction[14:12], addr[1:0]);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LU_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LU_IDLE: if (accept) state_next = misaligned ? LU_RESP : LU_REQ;
            LU_REQ:  if (mem_gnt) state_next = LU_WAIT;
            LU_WAIT: if (mem_rvalid || timeout_hit) state_next = LU_RESP;
            default: state_next = LU_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == LU_REQ);
        busy    = (state != LU_IDLE);
        resp    = (state == LU_RESP);
    end

    assign mem_addr  = word_q;
    assign fsm_state = state;

    load_extend #(.DATA_W(DATA_W)) u_extend (
        .funct3 (f3_q),
        .off    (off_q),
        .rdata  (mem_rdata),
        .ext    (ext_word)
    );

    // Faulting loads keep res_q at zero, so wb_data reads 0 for them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f3_q   <= '0;
            off_q  <= '0;
            word_q <= '0;
            res_q  <= '0;
            mis_q  <= 1'b0;
            flt_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            f3_q   <= instruction[14:12];
            off_q  <= addr[1:0];
            word_q <= {addr[DATA_W-1:2], 2'b00};
            res_q  <= '0;
            mis_q  <= misaligned;
            flt_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (state == LU_WAIT) begin
            if (mem_rvalid)       res_q <= ext_word;
            else if (timeout_hit) flt_q <= 1'b1;
            else                  cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Writeback is registered from RESP, so result fields are zero outside the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid        <= 1'b0;
            wb_data         <= '0;
            load_misaligned <= 1'b0;
            access_fault    <= 1'b0;
        end else begin
            wb_valid        <= resp;
            wb_data         <= resp ? res_q : '0;
            load_misaligned <= resp && mis_q;
            access_fault    <= resp && flt_q;
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed plan steps plus random loads
// against a behavioural reference of the load/extension/latency rules.
module tb_load_unit;

  localparam int TMO = 16;
  localparam logic [6:0] LOAD_OPC  = 7'b0000011;
  localparam logic [6:0] STORE_OPC = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        load_misaligned;
  logic        access_fault;
  logic [1:0]  fsm_state;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];

  load_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .instruction     (instruction),
    .addr            (addr),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .busy            (busy),
    .wb_valid        (wb_valid),
    .wb_data         (wb_data),
    .load_misaligned (load_misaligned),
    .access_fault    (access_fault),
    .fsm_state       (fsm_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] opc);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f3;
    r[6:0] = opc;
    return r;
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd2) ? 4 : 2;
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned off, bv, hv;
    off = a % 4;
    bv = (rd >> (8 * off)) % 256;
    hv = (rd >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
      3'd1:    return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
      3'd2:    return rd;
      3'd4:    return bv;
      3'd5:    return hv;
      default: return 32'h0;
    endcase
  endfunction

  // Driver: one load from the start cycle (cycle 0) through the cycle after its writeback.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input int gnt_dly, input int rv_dly,
                          input bit poke_rv, input bit inject);
    int cyc, req_cnt, gnt_cyc, wb_cyc, exp_wb, exp_req, wait_len;
    logic [31:0] got_data, exp_data, sb_data;
    logic got_mis, got_flt;
    bit exp_mis, exp_flt, addr_bad, busy_bad, sb_empty;

    exp_mis  = ref_misaligned(f3, a);
    wait_len = (rv_dly > TMO) ? TMO : rv_dly;
    exp_flt  = !exp_mis && (rv_dly > TMO);
    exp_data = (exp_mis || exp_flt) ? 32'h0 : ref_load(f3, a, rd);
    exp_wb   = exp_mis ? 2 : 1 + gnt_dly + wait_len + 2;
    exp_req  = exp_mis ? 0 : gnt_dly + 1;
    exp_q.push_back(exp_data);

    got_data = 'x; got_mis = 1'bx; got_flt = 1'bx;
    gnt_cyc = -1; wb_cyc = -1; req_cnt = 0; addr_bad = 0; busy_bad = 0;
    sb_data = 'x; sb_empty = 0;

    @(negedge clk);
    instruction = mk_instr(f3, LOAD_OPC);
    addr = a;
    start = 1'b1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      addr = $urandom;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      if (inject && cyc == 2) begin
        start = 1'b1;
        instruction = mk_instr(3'd2, LOAD_OPC);
        addr = $urandom & 32'hFFFF_FFFC;
      end
      if (wb_valid === 1'b1) begin
        wb_cyc = cyc;
        got_data = wb_data;
        got_mis = load_misaligned;
        got_flt = access_fault;
        start = 1'b0;
        if (exp_q.size() > 0) sb_data = exp_q.pop_front();
        else sb_empty = 1;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1;
      if (mem_req === 1'b1) begin
        req_cnt++;
        if (mem_addr !== {a[31:2], 2'b00}) addr_bad = 1;
        if (req_cnt > gnt_dly) begin
          mem_gnt = 1'b1;
          gnt_cyc = cyc;
          if (poke_rv) mem_rvalid = 1'b1;
        end
      end
      if (gnt_cyc >= 0 && cyc == gnt_cyc + rv_dly) begin
        mem_rvalid = 1'b1;
        mem_rdata = rd;
      end
    end

    tests++;
    if (wb_cyc !== exp_wb) begin
      fails++;
      $error("FAIL %s/wb_cycle: observed %0d expected %0d", tag, wb_cyc, exp_wb);
    end
    tests++;
    if (got_data !== exp_data) begin
      fails++;
      $error("FAIL %s/wb_data: observed %0h expected %0h", tag, got_data, exp_data);
    end
    tests++;
    if (sb_empty || got_data !== sb_data) begin
      fails++;
      $error("FAIL %s/scoreboard: observed %0h expected %0h", tag, got_data, sb_data);
    end
    tests++;
    if (got_mis !== exp_mis) begin
      fails++;
      $error("FAIL %s/misaligned: observed %0h expected %0h", tag, got_mis, exp_mis);
    end
    tests++;
    if (got_flt !== exp_flt) begin
      fails++;
      $error("FAIL %s/fault: observed %0h expected %0h", tag, got_flt, exp_flt);
    end
    tests++;
    if (req_cnt !== exp_req) begin
      fails++;
      $error("FAIL %s/req_cycles: observed %0d expected %0d", tag, req_cnt, exp_req);
    end
    tests++;
    if (addr_bad !== 1'b0) begin
      fails++;
      $error("FAIL %s/addr_stable: mem_addr moved or wrong", tag);
    end
    tests++;
    if (busy_bad !== 1'b0) begin
      fails++;
      $error("FAIL %s/busy: busy dropped while active", tag);
    end

    @(negedge clk);
    tests++;
    if (wb_valid !== 1'b0) begin
      fails++;
      $error("FAIL %s/wb_valid_after: observed %0h expected 0", tag, wb_valid);
    end
    tests++;
    if (wb_data !== 32'h0) begin
      fails++;
      $error("FAIL %s/wb_data_after: observed %0h expected 0", tag, wb_data);
    end
  endtask

  // Watch a few cycles after an ignored start: nothing may move.
  task automatic expect_quiet(input string tag, input int n);
    bit moved;
    moved = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_req !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) moved = 1;
    end
    tests++;
    if (moved !== 1'b0) begin
      fails++;
      $error("FAIL %s: unit reacted to an ignored start", tag);
    end
  endtask

  logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rrd;
    int          rg, rv;

    // Reset state
    repeat (3) @(negedge clk);
    tests++;
    if (mem_req !== 1'b0) begin fails++; $error("FAIL rst/mem_req: %0h", mem_req); end
    tests++;
    if (busy !== 1'b0) begin fails++; $error("FAIL rst/busy: %0h", busy); end
    tests++;
    if (wb_valid !== 1'b0) begin fails++; $error("FAIL rst/wb_valid: %0h", wb_valid); end
    tests++;
    if (wb_data !== 32'h0) begin fails++; $error("FAIL rst/wb_data: %0h", wb_data); end
    tests++;
    if (mem_addr !== 32'h0) begin fails++; $error("FAIL rst/mem_addr: %0h", mem_addr); end
    tests++;
    if (load_misaligned !== 1'b0) begin
      fails++; $error("FAIL rst/misaligned: %0h", load_misaligned);
    end
    tests++;
    if (access_fault !== 1'b0) begin fails++; $error("FAIL rst/fault: %0h", access_fault); end
    tests++;
    if (fsm_state !== 2'd0) begin fails++; $error("FAIL rst/state: %0h", fsm_state); end
    rst_n = 1'b1;

    // Directed plan steps
    run_load("lb_sign", 3'd0, 32'h0000_0103, 32'h80FF_1234, 0, 1, 0, 0);
    run_load("lbu", 3'd4, 32'h0000_0002, 32'h8765_C321, 0, 1, 0, 0);
    run_load("lhu", 3'd5, 32'h0000_0000, 32'h8765_C321, 0, 1, 0, 0);
    run_load("lh", 3'd1, 32'h0000_0002, 32'h8765_C321, 0, 1, 0, 0);
    run_load("lw", 3'd2, 32'h0000_0000, 32'h8765_C321, 0, 1, 0, 0);
    run_load("lw_misaligned", 3'd2, 32'h0000_0202, 32'h1234_5678, 0, 1, 0, 0);
    run_load("lh_misaligned", 3'd1, 32'h0000_0401, 32'h1234_5678, 0, 1, 0, 0);
    run_load("lhu_misaligned", 3'd5, 32'h0000_0403, 32'h1234_5678, 0, 1, 0, 0);
    run_load("stall_gnt", 3'd2, 32'h0000_0A0C, 32'hCAFE_F00D, 5, 1, 0, 0);
    run_load("timeout", 3'd2, 32'h0000_0B00, 32'hDEAD_BEEF, 0, 99, 0, 0);
    run_load("rvalid_at_limit", 3'd0, 32'h0000_0B01, 32'hDEAD_BEEF, 1, TMO, 0, 0);
    run_load("rvalid_in_resp", 3'd1, 32'h0000_0B02, 32'hDEAD_BEEF, 0, TMO + 1, 0, 0);
    run_load("rvalid_with_gnt", 3'd5, 32'h0000_0C02, 32'h0123_ABCD, 2, 2, 1, 0);
    run_load("start_while_busy", 3'd4, 32'h0000_0D01, 32'h0055_AA00, 1, 2, 0, 1);

    // Reset during WAIT, then a spurious rvalid
    @(negedge clk);
    instruction = mk_instr(3'd2, LOAD_OPC);
    addr = 32'h0000_0300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (mem_req !== 1'b1) begin fails++; $error("FAIL rst_wait/req: %0h", mem_req); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    tests++;
    if (fsm_state !== 2'd2) begin fails++; $error("FAIL rst_wait/in_wait: %0h", fsm_state); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (mem_req !== 1'b0) begin fails++; $error("FAIL rst_wait/req_drop: %0h", mem_req); end
    tests++;
    if (fsm_state !== 2'd0) begin fails++; $error("FAIL rst_wait/state: %0h", fsm_state); end
    mem_rvalid = 1'b1;
    mem_rdata = $urandom;
    expect_quiet("rst_wait/quiet", 6);
    run_load("after_reset", 3'd1, 32'h0000_0302, 32'hF00D_8001, 0, 1, 0, 0);

    // Non-load encodings are ignored
    @(negedge clk);
    instruction = mk_instr(3'd2, STORE_OPC);
    addr = 32'h0000_0400;
    start = 1'b1;
    expect_quiet("store_ignored", 6);
    @(negedge clk);
    instruction = mk_instr(3'd3, LOAD_OPC);
    start = 1'b1;
    expect_quiet("bad_funct3_ignored", 6);
    @(negedge clk);
    instruction = mk_instr(3'd6, LOAD_OPC);
    start = 1'b1;
    expect_quiet("f3_110_ignored", 6);
    run_load("after_ignored", 3'd0, 32'h0000_0401, 32'h0000_7F00, 0, 1, 0, 0);

    // Random loads
    for (int i = 0; i < 40; i++) begin
      rf3 = f3s[$urandom_range(0, 4)];
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rrd = $urandom;
      rg = $urandom_range(0, 3);
      rv = ($urandom_range(0, 5) == 0) ? $urandom_range(TMO - 2, TMO + 4)
                                       : $urandom_range(1, 3);
      run_load("rnd", rf3, ra, rrd, rg, rv, bit'($urandom_range(0, 1)), 1'b0);
    end

    // Final report
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $error("FAIL scoreboard: %0d expected results never observed", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
